// File: rtl/cnn_ctrl_pkg.sv
// rtl/cnn_ctrl_pkg.sv - shared control types and constants for the conv layer sequencers
package cnn_ctrl_pkg;

  // Result memories return q one cycle after the address is presented
  localparam int RD_LATENCY = 1;

  // Channel index as carried on the pooling stream
  localparam int CH_IDX_WIDTH = 3;
  typedef logic [CH_IDX_WIDTH-1:0] ch_idx_t;

  // Sequencer state encoding, shared by the launch FSM and the drain engine
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LAUNCH  = 3'd1;
  localparam state_t ST_WAIT    = 3'd2;
  localparam state_t ST_RD_ADDR = 3'd3;
  localparam state_t ST_RD_WAIT = 3'd4;
  localparam state_t ST_RD_OUT  = 3'd5;
  localparam state_t ST_FINISH  = 3'd6;
  localparam state_t ST_ERROR   = 3'd7;

endpackage

// File: rtl/conv1_result_drain.sv
// rtl/conv1_result_drain.sv - channel-major drain of all branch result memories into one stream
module conv1_result_drain
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int NUM_FILTERS  = 6,
  parameter int RESULT_DEPTH = 576
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_drain,
  input  logic [NUM_FILTERS*DATA_WIDTH-1:0] branch_result,
  input  logic                              out_ready,
  output logic [ADDR_WIDTH-1:0]             result_addr,
  output logic [DATA_WIDTH-1:0]             out_data,
  output ch_idx_t                           out_channel,
  output logic                              out_valid,
  output logic                              drain_done
);

  localparam int CH_W = $clog2(NUM_FILTERS);
  localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_FILTERS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RESULT_DEPTH - 1);

  state_t                phase;
  logic [CH_W-1:0]       ch;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] result_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  ch_idx_t               out_channel_q;
  logic [DATA_WIDTH-1:0] result_slice [NUM_FILTERS];
  logic                  last_word;
  logic                  last_ch;

  genvar g;
  generate
    for (g = 0; g < NUM_FILTERS; g++) begin : g_slice
      assign result_slice[g] = branch_result[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign last_word = (idx == LAST_IDX);
  assign last_ch   = (ch == LAST_CH);

  // Address, wait one read-latency cycle, then hold the captured word until accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase         <= ST_IDLE;
      ch            <= '0;
      idx           <= '0;
      result_addr_q <= '0;
      out_data_q    <= '0;
      out_channel_q <= '0;
    end else begin
      case (phase)
        ST_IDLE: begin
          if (start_drain) begin
            ch    <= '0;
            idx   <= '0;
            phase <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          result_addr_q <= idx;
          phase         <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          out_data_q    <= result_slice[ch];
          out_channel_q <= ch_idx_t'(ch);
          phase         <= ST_RD_OUT;
        end
        ST_RD_OUT: begin
          if (out_ready) begin
            if (!last_word) begin
              idx   <= idx + ADDR_WIDTH'(1);
              phase <= ST_RD_ADDR;
            end else if (!last_ch) begin
              ch    <= ch + CH_W'(1);
              idx   <= '0;
              phase <= ST_RD_ADDR;
            end else begin
              phase <= ST_IDLE;
            end
          end
        end
        default: phase <= ST_IDLE;
      endcase
    end
  end

  // The address is live during RD_ADDR and parked on the last one otherwise
  assign result_addr = (phase == ST_RD_ADDR) ? idx : result_addr_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign out_valid   = (phase == ST_RD_OUT);
  assign drain_done  = out_valid && out_ready && last_word && last_ch;

endmodule

// File: rtl/conv1_layer_scheduler.sv
// rtl/conv1_layer_scheduler.sv - launches conv1 branches in turn, then drains their results
module conv1_layer_scheduler
  import cnn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int NUM_FILTERS    = 6,
  parameter int RESULT_DEPTH   = 576,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [2:0]                        read_select,
  output logic [2:0]                        branch_read_select,
  output logic [NUM_FILTERS-1:0]            branch_run,
  input  logic [NUM_FILTERS-1:0]            branch_done,
  input  logic [NUM_FILTERS*ADDR_WIDTH-1:0] branch_addr,
  output logic [ADDR_WIDTH-1:0]             img_addr,
  output logic [ADDR_WIDTH-1:0]             result_addr,
  input  logic [NUM_FILTERS*DATA_WIDTH-1:0] branch_result,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [2:0]                        out_channel,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int CH_W = $clog2(NUM_FILTERS);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_FILTERS - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_SAT   = {WD_W{1'b1}};

  state_t                state;
  logic [CH_W-1:0]       ch;
  logic [WD_W-1:0]       watchdog;
  logic [2:0]            read_select_q;
  logic                  error_q;
  logic                  ch_done;
  logic                  start_drain;
  logic                  drain_done;
  logic [ADDR_WIDTH-1:0] addr_slice [NUM_FILTERS];

  genvar g;
  generate
    for (g = 0; g < NUM_FILTERS; g++) begin : g_addr
      assign addr_slice[g] = branch_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Only the active branch's done is looked at; the others are don't-care
  assign ch_done     = branch_done[ch];
  assign start_drain = (state == ST_WAIT) && ch_done && (ch == LAST_CH);

  // Launch FSM; the top parks in ST_RD_ADDR while the drain engine walks its own phases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ch            <= '0;
      watchdog      <= '0;
      read_select_q <= '0;
      error_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            read_select_q <= read_select;
            ch            <= '0;
            error_q       <= 1'b0;
            state         <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          watchdog <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ch_done) begin
            if (ch == LAST_CH) begin
              ch    <= '0;
              state <= ST_RD_ADDR;
            end else begin
              ch    <= ch + CH_W'(1);
              state <= ST_LAUNCH;
            end
          end else if (watchdog == WD_LIMIT) begin
            error_q <= 1'b1;
            state   <= ST_ERROR;
          end else if (watchdog != WD_SAT) begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        ST_RD_ADDR: begin
          if (drain_done) state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  conv1_result_drain #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_FILTERS (NUM_FILTERS),
    .RESULT_DEPTH(RESULT_DEPTH)
  ) u_drain (
    .clk          (clk),
    .reset        (reset),
    .start_drain  (start_drain),
    .branch_result(branch_result),
    .out_ready    (out_ready),
    .result_addr  (result_addr),
    .out_data     (out_data),
    .out_channel  (out_channel),
    .out_valid    (out_valid),
    .drain_done   (drain_done)
  );

  assign branch_read_select = read_select_q;
  assign branch_run = (state == ST_LAUNCH) ? (NUM_FILTERS'(1) << ch) : '0;
  assign img_addr   = (state == ST_WAIT) ? addr_slice[ch] : '0;
  assign busy       = (state != ST_IDLE) && (state != ST_ERROR);
  assign done       = (state == ST_FINISH);
  assign error      = error_q;

endmodule
